lcd_reader: RTL
===============

LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_AS, default 6, address setup cycles (RS/RW stable before E rises, 60 ns at 100 MHz).
REQ-002 Parameter T_EH, default 25, E-high cycles (250 ns; covers 230 ns PWEH and 160 ns data delay).
REQ-003 Parameter T_EL, default 25, E-low cycles after E falls (hold plus 500 ns minimum E cycle).
REQ-004 Parameter POLL_MAX, default 4096, maximum busy-flag reads per poll request.
REQ-005 clk  in  1  100 MHz system clock; the only clock in the block.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  1  start a read transaction; sampled only in IDLE.
REQ-008 req_rs  in  1  register select for the read: 0 = busy flag/address counter, 1 = DDRAM/CGRAM data.
REQ-009 req_poll  in  1  1 = repeat BF/AC reads until BF clears; forces RS=0.
REQ-010 ack  out  1  one-cycle pulse marking transaction completion.
REQ-011 rd_data  out  8  last captured LCD byte; valid when ack is high and held until the next capture.
REQ-012 timeout  out  1  qualifies ack; 1 = poll gave up with BF still set.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 bus_own  out  1  high while the reader owns the LCD bus; the top-level mux selects reader drive and releases the data pins.
REQ-015 lcd_rs, lcd_rw, lcd_en  out  1 each  HD44780 control lines.
REQ-016 lcd_data_in  in  8  LCD data pins, received through the top-level PMOD tristate.

Function
REQ-017 States SHALL be: IDLE, SETUP, EHIGH, ELOW, DONE.
REQ-018 IDLE SHALL go to SETUP on req=1; lcd_rs SHALL be set to (req_rs & ~req_poll), and lcd_rw and bus_own SHALL be set to 1 on that same edge.
REQ-019 SETUP SHALL last T_AS cycles, then go to EHIGH; lcd_en SHALL be 1 for exactly the T_EH cycles of EHIGH.
REQ-020 lcd_data_in SHALL be registered into rd_data on the last EHIGH cycle, i.e. the same edge that drops lcd_en.
REQ-021 ELOW SHALL last T_EL cycles; for a non-poll read, or a poll whose captured bit 7 is 0, it SHALL then go to DONE.
REQ-022 For a poll whose captured bit 7 is 1 and whose read count is below POLL_MAX, ELOW SHALL return to SETUP with RS/RW unchanged.
REQ-023 For a poll whose POLL_MAX-th read has bit 7 = 1, ELOW SHALL go to DONE with timeout=1.
REQ-024 DONE SHALL last one cycle, with ack=1, lcd_rw=0 and bus_own=0, then go to IDLE; timeout SHALL be valid only while ack=1 and SHALL be 0 otherwise.
REQ-025 Non-poll latency: with req sampled at edge N, lcd_en SHALL rise at edge N+6, fall at N+31, and ack SHALL be high in the cycle after edge N+56 (default parameters).
REQ-026 A req held high through DONE SHALL start a new transaction on the first IDLE cycle after ack.
REQ-027 req, req_rs and req_poll changes SHALL be ignored outside IDLE.
REQ-028 The phase counter SHALL be wide enough for max(T_AS, T_EH, T_EL); the poll counter SHALL be clog2(POLL_MAX+1) bits and SHALL never wrap.
REQ-029 The block SHALL never drive lcd_en high unless bus_own=1 and lcd_rw=1.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE; lcd_en, lcd_rs, lcd_rw, bus_own, ack, timeout and busy = 0; rd_data = 8'h00; counters = 0.
REQ-031 Reset during EHIGH SHALL drop lcd_en within the same cycle, with no ack issued.
REQ-032 After rst_n rises, the first req SHALL be accepted on the first clk edge.

Structure
REQ-033 Package lcd_pkg SHALL hold the state enum, default timing constants and HD44780 bit positions (BF = bit 7, AC = bits 6:0), shared with the LCD writer.
REQ-034 One sub-module, lcd_phase_timer: a loadable down-counter with a done pulse, reused for SETUP/EHIGH/ELOW.
REQ-035 Top-level integration: the reader and writer are muxed on bus_own; the PMOD data pins tristate while bus_own=1.

Verification
REQ-036 Single data read: req=1, req_rs=1, LCD model drives 8'hA5 -> lcd_rs=1, lcd_en high for 25 cycles, ack at N+56, rd_data=8'hA5, timeout=0.
REQ-037 Poll clears: model returns 8'h80, 8'h80, 8'h12 -> exactly three E pulses, ack with rd_data=8'h12, timeout=0.
REQ-038 Poll timeout: POLL_MAX=4, model always returns 8'hFF -> four E pulses, ack with timeout=1, rd_data=8'hFF.
REQ-039 Reset mid-EHIGH: assert rst_n=0 at cycle N+15 -> lcd_en=0 and bus_own=0 in the same cycle, no ack, next req completes normally.
REQ-040 Back-to-back: req held high across two transactions -> second SETUP starts the cycle after ack; E cycle >= 56 cycles; lcd_en never high while lcd_rw=0.

Source files
------------

// File: rtl/lcd_pkg.sv
//------------------------------------------------------------------------------
// Module : lcd_pkg
// Brief  : Shared HD44780 definitions for the LCD reader and writer: FSM state
//          encoding, default bus timing (100 MHz clock) and register bit
//          positions.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  // Reader FSM states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EHIGH = 3'd2,
    ST_ELOW  = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_e;

  // Default bus timing in 10 ns clock cycles
  localparam int unsigned LCD_T_AS_DEF    = 6;    // 60 ns RS/RW setup
  localparam int unsigned LCD_T_EH_DEF    = 25;   // 250 ns E high
  localparam int unsigned LCD_T_EL_DEF    = 25;   // 250 ns E low / hold
  localparam int unsigned LCD_POLL_MAX_DEF = 4096;

  // HD44780 status register layout
  localparam int unsigned LCD_BF_BIT = 7;   // busy flag
  localparam int unsigned LCD_AC_MSB = 6;   // address counter msb
  localparam int unsigned LCD_AC_LSB = 0;   // address counter lsb

  // Largest of three timing values; sizes the shared phase counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage : lcd_pkg

`default_nettype wire

// File: rtl/lcd_phase_timer.sv
//------------------------------------------------------------------------------
// Module : lcd_phase_timer
// Brief  : Loadable down-counter. A load sets the phase length; done_o is high
//          during the last cycle of the phase (count == 1), so the caller can
//          transition and reload on the same edge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_phase_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Load has priority; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  assign done_o = (cnt_q == WIDTH'(1));

endmodule : lcd_phase_timer

`default_nettype wire

// File: rtl/lcd_reader.sv
//------------------------------------------------------------------------------
// Module : lcd_reader
// Brief  : HD44780 read engine. Performs a single BF/AC or data read, or polls
//          the busy flag until it clears (bounded by POLL_MAX reads). Drives
//          RS/RW/E and requests bus ownership from the top-level mux.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS     = LCD_T_AS_DEF,
  parameter int unsigned T_EH     = LCD_T_EH_DEF,
  parameter int unsigned T_EL     = LCD_T_EL_DEF,
  parameter int unsigned POLL_MAX = LCD_POLL_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       req_rs_i,
  input  logic       req_poll_i,
  output logic       ack_o,
  output logic [7:0] rd_data_o,
  output logic       timeout_o,
  output logic       busy_o,
  output logic       bus_own_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  input  logic [7:0] lcd_data_in_i
);

  localparam int unsigned PH_W = $clog2(max3(T_AS, T_EH, T_EL) + 1);
  localparam int unsigned PC_W = $clog2(POLL_MAX + 1);

  lcd_state_e        state_q;
  lcd_state_e        state_d;

  logic              rs_q;
  logic              poll_q;
  logic [7:0]        rd_data_q;
  logic [PC_W-1:0]   poll_cnt_q;
  logic              timeout_q;

  logic              ph_load;
  logic [PH_W-1:0]   ph_val;
  logic              ph_done;

  logic              w_bf_set;
  logic              w_cnt_below;
  logic              w_retry;
  logic              w_gave_up;

  // Poll decision uses the byte captured on the most recent E fall
  assign w_bf_set    = rd_data_q[LCD_BF_BIT];
  assign w_cnt_below = (poll_cnt_q < PC_W'(POLL_MAX));
  assign w_retry     = poll_q & w_bf_set & w_cnt_below;
  assign w_gave_up   = poll_q & w_bf_set & ~w_cnt_below;

  // One timer serves SETUP, EHIGH and ELOW; reloaded on every state change
  lcd_phase_timer #(
    .WIDTH (PH_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .done_o     (ph_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_i)   state_d = ST_SETUP;
      ST_SETUP: if (ph_done) state_d = ST_EHIGH;
      ST_EHIGH: if (ph_done) state_d = ST_ELOW;
      ST_ELOW:  if (ph_done) state_d = w_retry ? ST_SETUP : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Phase length for the state being entered
  always_comb begin
    ph_load = (state_d != state_q);
    ph_val  = '0;
    case (state_d)
      ST_SETUP: ph_val = PH_W'(T_AS);
      ST_EHIGH: ph_val = PH_W'(T_EH);
      ST_ELOW:  ph_val = PH_W'(T_EL);
      default:  ph_val = '0;
    endcase
  end

  // Request capture, data capture on E fall, poll count and timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_i) begin
        rs_q       <= req_rs_i & ~req_poll_i;
        poll_q     <= req_poll_i;
        poll_cnt_q <= '0;
      end
      if (state_q == ST_EHIGH && ph_done) begin
        rd_data_q <= lcd_data_in_i;
        if (poll_q && w_cnt_below) begin
          poll_cnt_q <= poll_cnt_q + PC_W'(1);
        end
      end
      // High only for the single DONE cycle that follows a give-up
      timeout_q <= (state_q == ST_ELOW) & ph_done & w_gave_up;
    end
  end

  // Outputs decoded from state; E is only possible while the bus is owned
  always_comb begin
    busy_o    = (state_q != ST_IDLE);
    bus_own_o = (state_q == ST_SETUP) || (state_q == ST_EHIGH) ||
                (state_q == ST_ELOW);
    lcd_rw_o  = bus_own_o;
    lcd_en_o  = (state_q == ST_EHIGH);
    ack_o     = (state_q == ST_DONE);
    timeout_o = timeout_q;
    lcd_rs_o  = rs_q;
    rd_data_o = rd_data_q;
  end

endmodule : lcd_reader

`default_nettype wire
